// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone classic manager.
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    DONE     = 2'd2
  } wb_state_t;

  localparam logic [3:0]  WB_SEL_ALL      = 4'hF;
  localparam logic [31:0] WB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/wb_timeout_counter.sv
// ACK watchdog: counts WAIT_ACK cycles without ACK_I and flags the cycle in
// which the limit is reached. Only instantiated when WB_TIMEOUT_EN is defined.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8;

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + CNT_W'(1);
    end
  end

  // count holds the number of ACK-less cycles already spent, so the limit
  // is hit during the LIMIT-th waiting cycle itself.
  assign expired = count_en && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/wishbone_manager.sv
// Wishbone classic manager: one single read/write bus cycle per CPU request.
// Define WB_TIMEOUT_EN to add the ACK timeout (err_o port, TIMEOUT_CYCLES).
module wishbone_manager
  import wb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] cpu_dat_i,
  input  logic [3:0]        sel_i,
  output logic              busy_o,
  output logic [DATA_W-1:0] cpu_dat_o,
  output logic [ADDR_W-1:0] ADR_O,
  output logic [DATA_W-1:0] DAT_O,
  output logic [3:0]        SEL_O,
  output logic              WE_O,
  output logic              CYC_O,
  output logic              STB_O,
  input  logic              ACK_I,
  input  logic [DATA_W-1:0] DAT_I
`ifdef WB_TIMEOUT_EN
  ,
  output logic              err_o
`endif
);

  wb_state_t state, state_next;
  logic      accept;
  logic      ack_take;
  logic      timeout_take;
  logic      timeout_hit;

`ifdef WB_TIMEOUT_EN
  wb_timeout_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .count_en((state == WAIT_ACK) && !ACK_I),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE always returns to IDLE so a still-held request is not re-issued
  // while the CPU samples the result.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    ack_take     = 1'b0;
    timeout_take = 1'b0;
    busy_o       = 1'b0;
    case (state)
      IDLE: begin
        if (read_i || write_i) begin
          accept     = 1'b1;
          busy_o     = 1'b1;
          state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        busy_o = 1'b1;
        if (ACK_I) begin
          ack_take   = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          timeout_take = 1'b1;
          state_next   = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // WE_O still reflects the transaction direction while waiting, so it
  // selects whether the returned data is captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ADR_O     <= '0;
      DAT_O     <= '0;
      SEL_O     <= '0;
      WE_O      <= 1'b0;
      CYC_O     <= 1'b0;
      STB_O     <= 1'b0;
      cpu_dat_o <= '0;
`ifdef WB_TIMEOUT_EN
      err_o     <= 1'b0;
`endif
    end else begin
`ifdef WB_TIMEOUT_EN
      err_o <= timeout_take;
`endif
      if (accept) begin
        ADR_O <= adr_i;
        if (write_i) begin
          DAT_O <= cpu_dat_i;
        end
        SEL_O <= sel_i;
        WE_O  <= write_i;
        CYC_O <= 1'b1;
        STB_O <= 1'b1;
      end else if (ack_take || timeout_take) begin
        CYC_O <= 1'b0;
        STB_O <= 1'b0;
        WE_O  <= 1'b0;
        if (!WE_O) begin
          cpu_dat_o <= ack_take ? DAT_I : DATA_W'(WB_TIMEOUT_DATA);
        end
      end
    end
  end

endmodule

// File: tb/tb_wishbone_manager.sv
// Self-checking bench for wishbone_manager: directed scenarios plus random
// requests and a random-latency slave, all checked against a behavioural model.
module tb_wishbone_manager;
  import wb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int TB_TIMEOUT = 4;
`ifdef WB_TIMEOUT_EN
  localparam int MAX_WAIT   = 6;
`else
  localparam int MAX_WAIT   = 3;
`endif

  logic              clk;
  logic              rst;
  logic              read_i;
  logic              write_i;
  logic [ADDR_W-1:0] adr_i;
  logic [DATA_W-1:0] cpu_dat_i;
  logic [3:0]        sel_i;
  logic              busy_o;
  logic [DATA_W-1:0] cpu_dat_o;
  logic [ADDR_W-1:0] ADR_O;
  logic [DATA_W-1:0] DAT_O;
  logic [3:0]        SEL_O;
  logic              WE_O;
  logic              CYC_O;
  logic              STB_O;
  logic              ACK_I;
  logic [DATA_W-1:0] DAT_I;
`ifdef WB_TIMEOUT_EN
  logic              err_o;
`endif

  wishbone_manager #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .TIMEOUT_CYCLES(TB_TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .read_i   (read_i),
    .write_i  (write_i),
    .adr_i    (adr_i),
    .cpu_dat_i(cpu_dat_i),
    .sel_i    (sel_i),
    .busy_o   (busy_o),
    .cpu_dat_o(cpu_dat_o),
    .ADR_O    (ADR_O),
    .DAT_O    (DAT_O),
    .SEL_O    (SEL_O),
    .WE_O     (WE_O),
    .CYC_O    (CYC_O),
    .STB_O    (STB_O),
`ifdef WB_TIMEOUT_EN
    .err_o    (err_o),
`endif
    .ACK_I    (ACK_I),
    .DAT_I    (DAT_I)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_done   = 0;
  int checks_failed = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks_done++;
    if (actual !== expected) begin
      checks_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change 2 time units after a rising edge, so they are stable
  // from the falling edge (model sampling) through the next rising edge.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [ADDR_W-1:0] adr,
                               input logic [DATA_W-1:0] dat, input logic [3:0] sel);
    @(posedge clk);
    #2;
    read_i    = rd;
    write_i   = wr;
    adr_i     = adr;
    cpu_dat_i = dat;
    sel_i     = sel;
  endtask

  // Slave: ACKs once CYC/STB have been seen for slave_wait extra cycles.
  int          slave_wait   = 0;
  int          slave_cnt    = 0;
  bit          slave_random = 1'b0;
  logic [31:0] slave_data   = '0;

  always @(posedge clk) begin
    #2;
    if (CYC_O && STB_O) begin
      if (slave_cnt >= slave_wait) begin
        ACK_I = 1'b1;
        DAT_I = slave_random ? $urandom : slave_data;
      end else begin
        ACK_I = 1'b0;
        slave_cnt++;
      end
    end else begin
      slave_cnt = 0;
      if (slave_random) begin
        slave_wait = $urandom_range(0, MAX_WAIT);
        ACK_I      = ($urandom_range(0, 3) == 0);
        DAT_I      = $urandom;
      end else begin
        ACK_I = 1'b0;
      end
    end
  end

  // Behavioural model: what the CPU and the bus should see, cycle by cycle.
  bit              m_in_txn;
  bit              m_gap;
  bit              m_is_write;
  bit              m_cyc;
  bit              m_we;
  logic [ADDR_W-1:0] m_adr;
  logic [DATA_W-1:0] m_dat;
  logic [3:0]      m_sel;
  logic [DATA_W-1:0] m_rdata;
  int              m_waited;
  bit              m_err;

  task automatic modelFinish(input logic [DATA_W-1:0] rdata);
    m_in_txn = 1'b0;
    m_gap    = 1'b1;
    m_cyc    = 1'b0;
    m_we     = 1'b0;
    if (!m_is_write) m_rdata = rdata;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      m_in_txn = 0; m_gap = 0; m_is_write = 0; m_cyc = 0; m_we = 0;
      m_adr = '0; m_dat = '0; m_sel = '0; m_rdata = '0; m_waited = 0; m_err = 0;
    end
    checkOutput("busy_o", busy_o, m_in_txn || (!m_gap && (read_i || write_i)));
    checkOutput("CYC_O", CYC_O, m_cyc);
    checkOutput("STB_O", STB_O, m_cyc);
    checkOutput("WE_O", WE_O, m_we);
    checkOutput("ADR_O", ADR_O, m_adr);
    checkOutput("DAT_O", DAT_O, m_dat);
    checkOutput("SEL_O", SEL_O, m_sel);
    checkOutput("cpu_dat_o", cpu_dat_o, m_rdata);
`ifdef WB_TIMEOUT_EN
    checkOutput("err_o", err_o, m_err);
`endif
    if (rst) begin
      m_err = 1'b0;
      if (m_gap) begin
        m_gap = 1'b0;
      end else if (m_in_txn) begin
        if (ACK_I) begin
          modelFinish(DAT_I);
        end else begin
          m_waited++;
`ifdef WB_TIMEOUT_EN
          if (m_waited == TB_TIMEOUT) begin
            modelFinish(WB_TIMEOUT_DATA);
            m_err = 1'b1;
          end
`endif
        end
      end else if (read_i || write_i) begin
        m_in_txn   = 1'b1;
        m_is_write = write_i;
        m_cyc      = 1'b1;
        m_we       = write_i;
        m_adr      = adr_i;
        m_sel      = sel_i;
        m_waited   = 0;
        if (write_i) m_dat = cpu_dat_i;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit exp_cyc  [5] = '{0, 1, 0, 0, 1};
    bit exp_busy [5] = '{1, 1, 0, 1, 1};

    rst = 1'b0; read_i = 0; write_i = 0; adr_i = '0; cpu_dat_i = '0; sel_i = '0;
    ACK_I = 1'b0; DAT_I = '0;
    @(negedge clk);
    checkOutput("reset_cyc", CYC_O, 0);
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_cpu_dat", cpu_dat_o, 0);
    @(posedge clk); #2; rst = 1'b1;

    // Single read, ACK one cycle after the strobe
    slave_wait = 0; slave_data = 32'h1234_5678;
    applyStimulus(1, 0, 32'h0000_0040, '0, WB_SEL_ALL);
    @(negedge clk);
    checkOutput("rd_busy_req", busy_o, 1);
    applyStimulus(0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("rd_cyc", CYC_O, 1);
    checkOutput("rd_we", WE_O, 0);
    checkOutput("rd_adr", ADR_O, 32'h0000_0040);
    @(negedge clk);
    checkOutput("rd_done_busy", busy_o, 0);
    checkOutput("rd_done_cyc", CYC_O, 0);
    checkOutput("rd_done_data", cpu_dat_o, 32'h1234_5678);

    // Write with five strobe cycles
    slave_wait = 4;
    applyStimulus(0, 1, 32'h0000_0080, 32'hCAFE_F00D, 4'hF);
    applyStimulus(0, 0, '0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("wr_cyc", CYC_O, 1);
      checkOutput("wr_we", WE_O, 1);
      checkOutput("wr_adr", ADR_O, 32'h0000_0080);
      checkOutput("wr_dat", DAT_O, 32'hCAFE_F00D);
      checkOutput("wr_sel", SEL_O, 4'hF);
    end
    @(negedge clk);
    checkOutput("wr_done_cyc", CYC_O, 0);
    checkOutput("wr_done_we", WE_O, 0);
    checkOutput("wr_cpu_dat_kept", cpu_dat_o, 32'h1234_5678);

    // Read and write together: write wins
    slave_wait = 0;
    applyStimulus(1, 1, 32'h0000_00C0, 32'h55AA_55AA, 4'h3);
    applyStimulus(0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("both_we", WE_O, 1);
    checkOutput("both_sel", SEL_O, 4'h3);
    checkOutput("both_dat", DAT_O, 32'h55AA_55AA);
    @(negedge clk);
    checkOutput("both_cpu_dat_kept", cpu_dat_o, 32'h1234_5678);

    // Held read: DONE gap, then re-accept
    slave_data = 32'hA5A5_0001;
    applyStimulus(1, 0, 32'h0000_0100, '0, 4'hF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("held_cyc%0d", i), CYC_O, exp_cyc[i]);
      checkOutput($sformatf("held_busy%0d", i), busy_o, exp_busy[i]);
    end
    checkOutput("held_data", cpu_dat_o, 32'hA5A5_0001);
    applyStimulus(0, 0, '0, '0, '0);
    repeat (2) @(negedge clk);

    // Asynchronous reset in WAIT_ACK
    slave_wait = 1000;
    applyStimulus(1, 0, 32'h0000_0200, '0, 4'hF);
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0; read_i = 1'b0;
    #1;
    checkOutput("rst_async_cyc", CYC_O, 0);
    checkOutput("rst_async_stb", STB_O, 0);
    checkOutput("rst_async_busy", busy_o, 0);
    repeat (2) @(posedge clk);
    #2; rst = 1'b1;
    slave_wait = 0; slave_data = 32'h0BAD_F00D;
    applyStimulus(1, 0, 32'h0000_0044, '0, 4'hF);
    applyStimulus(0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("post_rst_cyc", CYC_O, 1);
    @(negedge clk);
    checkOutput("post_rst_data", cpu_dat_o, 32'h0BAD_F00D);

`ifdef WB_TIMEOUT_EN
    // No ACK: timeout after four waiting cycles
    slave_wait = 1000;
    applyStimulus(1, 0, 32'h0000_0300, '0, 4'hF);
    applyStimulus(0, 0, '0, '0, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("to_cyc", CYC_O, 1);
    end
    @(negedge clk);
    checkOutput("to_err", err_o, 1);
    checkOutput("to_cyc_drop", CYC_O, 0);
    checkOutput("to_data", cpu_dat_o, WB_TIMEOUT_DATA);
    @(negedge clk);
    checkOutput("to_err_pulse", err_o, 0);

    // ACK in the fourth waiting cycle beats the timeout
    slave_wait = 3; slave_data = 32'h7777_1111;
    applyStimulus(1, 0, 32'h0000_0304, '0, 4'hF);
    applyStimulus(0, 0, '0, '0, '0);
    repeat (5) @(negedge clk);
    checkOutput("late_ack_err", err_o, 0);
    checkOutput("late_ack_data", cpu_dat_o, 32'h7777_1111);
`endif

    // Random requests against a random-latency slave
    slave_random = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                    $urandom, $urandom, 4'($urandom));
    end
    applyStimulus(0, 0, '0, '0, '0);
    slave_random = 1'b0;
    slave_wait   = 0;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule

// File: doc/wishbone_manager.md
Name: wishbone_manager

Overview:
- Bus-side responder for the CPU request unit. Accepts the CPU's read/write requests: read_i, write_i, adr_i, cpu_dat_i, sel_i.
- Runs exactly one Wishbone classic (non-pipelined) single cycle per request to memory/SRAM.
- Returns busy_o and read data cpu_dat_o to the CPU.
- Sits between the request unit and the Wishbone interconnect; one outstanding transaction at a time.

Parameters:
- ADDR_W, 32, width of adr_i and ADR_O.
- DATA_W, 32, width of all data paths.
- TIMEOUT_CYCLES, 255, ACK wait limit. Only used when WB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- read_i  in  1  CPU read request, level, held until serviced
- write_i  in  1  CPU write request, level, held until serviced
- adr_i  in  ADDR_W  CPU byte address
- cpu_dat_i  in  DATA_W  CPU write data
- sel_i  in  4  CPU byte enables
- busy_o  out  1  transaction in progress
- cpu_dat_o  out  DATA_W  read data returned to CPU
- ADR_O  out  ADDR_W  Wishbone address
- DAT_O  out  DATA_W  Wishbone write data
- SEL_O  out  4  Wishbone byte select
- WE_O  out  1  Wishbone write enable
- CYC_O  out  1  Wishbone cycle
- STB_O  out  1  Wishbone strobe
- ACK_I  in  1  Wishbone acknowledge
- DAT_I  in  DATA_W  Wishbone read data
- err_o  out  1  timeout pulse. Present only with WB_TIMEOUT_EN.

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. All registered outputs go to 0 and state goes to IDLE. If reset hits mid-cycle, CYC_O/STB_O drop immediately and the transaction is lost.
- States: IDLE, WAIT_ACK, DONE.
- IDLE:
  - If write_i=1, start a write. Write has priority when read_i and write_i are both high.
  - Else if read_i=1, start a read.
  - On acceptance, register ADR_O<=adr_i, DAT_O<=cpu_dat_i (write only, else hold), SEL_O<=sel_i, WE_O<=write_i, CYC_O=STB_O<=1, then go to WAIT_ACK.
  - With no request, stay in IDLE.
- WAIT_ACK:
  - Hold all bus outputs stable until ACK_I=1.
  - On ACK_I: CYC_O, STB_O, WE_O <= 0. For a read, cpu_dat_o <= DAT_I; for a write, cpu_dat_o holds its old value. Go to DONE.
  - ACK_I outside WAIT_ACK is ignored.
- DONE:
  - Lasts one cycle, then returns to IDLE unconditionally.
  - busy_o=0 and cpu_dat_o is valid.
  - read_i/write_i are ignored, so a request still held high is not re-issued while the CPU samples the result.
- busy_o is combinational: 1 when state==WAIT_ACK, or when state==IDLE and (read_i|write_i). Otherwise 0, including in DONE.
- Latency: request seen in IDLE (cycle 0); earliest ACK at cycle 1; DONE at cycle 2 (busy_o low, data valid). A held request is re-accepted no earlier than cycle 3.
- cpu_dat_o keeps its value until the next read completes.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT_ACK and increments each WAIT_ACK cycle without ACK_I.
  - When it reaches TIMEOUT_CYCLES: CYC_O/STB_O drop, cpu_dat_o <= 32'hDEAD_BEEF for reads, err_o pulses for 1 cycle, and state goes to DONE.
  - ACK_I arriving in the same cycle as the timeout wins; no error is raised.
- Not defined: no counter and no err_o port; WAIT_ACK waits indefinitely.

Decomposition:
- Shared package wb_pkg:
  - typedef enum logic [1:0] wb_state_t {IDLE, WAIT_ACK, DONE}
  - localparam WB_SEL_ALL = 4'hF
  - localparam WB_TIMEOUT_DATA = 32'hDEAD_BEEF
- One natural sub-module: wb_timeout_counter (counter plus compare, only instantiated under WB_TIMEOUT_EN).

Test Plan:
- Read: read_i=1, adr_i=32'h0000_0040, slave ACKs 1 cycle later with DAT_I=32'h1234_5678 -> CYC/STB high 1 cycle, WE_O=0; DONE cycle has busy_o=0, cpu_dat_o=32'h1234_5678.
- Write with wait states: write_i=1, adr_i=32'h0000_0080, cpu_dat_i=32'hCAFE_F00D, sel_i=4'hF, ACK after 5 cycles -> ADR_O/DAT_O/SEL_O/WE_O=1 stable all 5 cycles; cpu_dat_o unchanged.
- Simultaneous read_i=write_i=1 -> WE_O=1 (write wins).
- Held request: read_i held high across completion -> exactly one bus cycle per accept, with a 1-cycle DONE gap (busy_o=0) before the second CYC_O.
- Reset: deassert rst during WAIT_ACK -> CYC_O/STB_O/busy_o=0 asynchronously; after release, state is IDLE and a new read completes normally.
- WB_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ACK -> err_o pulse, cpu_dat_o=32'hDEAD_BEEF, CYC_O drops; ACK on the 4th cycle -> no error.
